// File: rtl/spi_a2d_pkg.sv
// Purpose : shared FSM state type and default parameter values for the SPI A2D model.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package spi_a2d_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SKIP_1st = 2'd1,
        SHIFT    = 2'd2
    } state_t;

    localparam int          DEF_FRAME_W    = 16;
    localparam int          DEF_DATA_W     = 12;
    localparam int          DEF_NUM_CH     = 8;
    localparam int          DEF_ADDR_LSB   = 11;
    localparam logic [15:0] DEF_FIRST_WORD = 16'hABCD;

endpackage

// File: rtl/spi_edge_det.sv
// Purpose : two-flop SCLK synchroniser with single-cycle rise/fall pulses in the clk domain.
// Latency : an SCLK transition shows up as a pulse 2 clk edges later.
// Backpressure: none; events cannot be stalled.
// Ports   : clk, rst_n (sync, active-low), SCLK (async serial clock) -> rise, fall.
module spi_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic SCLK,
    output logic rise,
    output logic fall
);

    logic r_ff1;
    logic r_ff2;

    // Both flops reset high so an idle-high SCLK produces no spurious edge after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ff1 <= 1'b1;
            r_ff2 <= 1'b1;
        end else begin
            r_ff1 <= SCLK;
            r_ff2 <= r_ff1;
        end
    end

    assign rise = r_ff1 & ~r_ff2;
    assign fall = ~r_ff1 & r_ff2;

endmodule

// File: rtl/spi_a2d_mch.sv
// Purpose : SPI slave modelling a multi-channel A2D; returns a channel result per frame.
// Latency : reply word loaded 1 clk after SS_n low; rdy/chnl update 1 clk after SS_n high.
// Backpressure: none; the SPI master owns the pace, rdy just flags completion.
// Ports   : clk, rst_n (sync, active-low), SS_n, SCLK, MOSI, A2D_data -> MISO (Z when
//           deselected), cmd, chnl, rdy, frame_err.
// Config  : define LOOPBACK_EN to echo the previous command word instead of channel data.
module spi_a2d_mch
    import spi_a2d_pkg::*;
#(
    parameter int                 FRAME_W    = DEF_FRAME_W,
    parameter int                 DATA_W     = DEF_DATA_W,
    parameter int                 NUM_CH     = DEF_NUM_CH,
    parameter int                 ADDR_LSB   = DEF_ADDR_LSB,
    parameter logic [FRAME_W-1:0] FIRST_WORD = FRAME_W'(DEF_FIRST_WORD)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       SS_n,
    input  logic                       SCLK,
    input  logic                       MOSI,
    input  logic [NUM_CH*DATA_W-1:0]   A2D_data,
    output logic                       MISO,
    output logic [FRAME_W-1:0]         cmd,
    output logic [$clog2(NUM_CH)-1:0]  chnl,
    output logic                       rdy,
    output logic                       frame_err
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(FRAME_W + 1);

    state_t               r_state;
    logic [FRAME_W-1:0]   r_tx;
    logic [FRAME_W-1:0]   r_rx;
    logic [CNT_W-1:0]     r_cnt;
    logic [CH_W-1:0]      r_chnl;
    logic                 r_first;
    logic                 r_rdy;
    logic                 r_err;

    logic                 w_rise;
    logic                 w_fall;
    logic [FRAME_W-1:0]   w_rx_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [FRAME_W-1:0]   w_load;

    spi_edge_det u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .SCLK  (SCLK),
        .rise  (w_rise),
        .fall  (w_fall)
    );

    // Receive shift and bit count are computed combinationally so the frame-end
    // branch can latch chnl/frame_err including a rise landing in the same cycle.
    always_comb begin
        w_rx_nxt  = r_rx;
        w_cnt_nxt = r_cnt;
        if (r_state != IDLE && w_rise) begin
            w_rx_nxt = {r_rx[FRAME_W-2:0], MOSI};
            if (r_cnt != '1)
                w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    // Reply word for the frame about to start, right-justified with zero pad.
    always_comb begin
        w_load = '0;
        if (r_first) begin
            w_load = FIRST_WORD;
        end else begin
`ifdef LOOPBACK_EN
            w_load = r_rx;
`else
            w_load[DATA_W-1:0] = A2D_data[r_chnl*DATA_W +: DATA_W];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_tx    <= '0;
            r_rx    <= '0;
            r_cnt   <= '0;
            r_chnl  <= '0;
            r_first <= 1'b1;
            r_rdy   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_rx  <= w_rx_nxt;
            r_cnt <= w_cnt_nxt;
            case (r_state)
                IDLE: begin
                    if (!SS_n) begin
                        r_rdy   <= 1'b0;
                        r_err   <= 1'b0;
                        r_tx    <= w_load;
                        r_first <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= SKIP_1st;
                    end
                end
                SKIP_1st, SHIFT: begin
                    // The leading SCLK fall only arms the shifter; MISO already holds the MSB.
                    if (r_state == SHIFT && w_fall)
                        r_tx <= {r_tx[FRAME_W-2:0], 1'b0};
                    if (SS_n) begin
                        r_state <= IDLE;
                        r_rdy   <= 1'b1;
                        r_err   <= (w_cnt_nxt != CNT_W'(FRAME_W));
                        r_chnl  <= w_rx_nxt[ADDR_LSB +: CH_W];
                    end else if (r_state == SKIP_1st && w_fall) begin
                        r_state <= SHIFT;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign MISO      = SS_n ? 1'bz : r_tx[FRAME_W-1];
    assign cmd       = r_rx;
    assign chnl      = r_chnl;
    assign rdy       = r_rdy;
    assign frame_err = r_err;

endmodule

// File: doc/spi_a2d_mch.md
SPI_A2D_MCH -- requirements
Module: spi_a2d_mch

Interface
REQ-001 The block SHALL have parameter FRAME_W, default 16, meaning SPI frame length in bits.
REQ-002 The block SHALL have parameter DATA_W, default 12, meaning conversion result width, with DATA_W <= FRAME_W.
REQ-003 The block SHALL have parameter NUM_CH, default 8, meaning number of modelled A2D channels (power of 2, >= 2).
REQ-004 The block SHALL have parameter ADDR_LSB, default 11, meaning LSB position of the channel-address field in the received command.
REQ-005 The block SHALL have parameter FIRST_WORD, default 16'hABCD, meaning the word returned in the first frame after reset.
REQ-006 The block SHALL have the port clk, input, 1 bit: system clock; all logic is clocked on its rising edge.
REQ-007 The block SHALL have the port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-008 The block SHALL have the port SS_n, input, 1 bit: active-low slave select.
REQ-009 The block SHALL have the port SCLK, input, 1 bit: serial clock, asynchronous to clk.
REQ-010 The block SHALL have the port MOSI, input, 1 bit: serial data from master.
REQ-011 The block SHALL have the port A2D_data, input, NUM_CH*DATA_W bits: flattened channel results, with channel k at bits [k*DATA_W +: DATA_W].
REQ-012 The block SHALL have the port MISO, output, 1 bit: serial data to master; high-Z while SS_n=1.
REQ-013 The block SHALL have the port cmd, output, FRAME_W bits: last received command word.
REQ-014 The block SHALL have the port chnl, output, $clog2(NUM_CH) bits: channel address latched from the last completed frame.
REQ-015 The block SHALL have the port rdy, output, 1 bit: transaction complete.
REQ-016 The block SHALL have the port frame_err, output, 1 bit: the last frame had a SCLK-rise count other than FRAME_W.

Function
REQ-017 The block SHALL synchronise SCLK through two flops (both reset to 1); rise = ff1 & ~ff2, fall = ~ff1 & ff2.
REQ-018 The state machine SHALL have the states IDLE, SKIP_1st and SHIFT.
REQ-019 IDLE: when SS_n=0 is sampled, the block SHALL clear rdy and frame_err, load the tx register, reset the bit counter to 0, and go to SKIP_1st.
REQ-020 The tx load value SHALL be FIRST_WORD for the first frame after reset, and {zero pad, A2D_data channel chnl} (right-justified) for every later frame.
REQ-021 SKIP_1st: the block SHALL sample MOSI into the rx register on each rise and go to SHIFT on the first fall without shifting tx.
REQ-022 SHIFT: the block SHALL shift tx left (0 fill) on fall and shift MOSI into rx on rise.
REQ-023 The bit counter SHALL increment on every rise in SKIP_1st and SHIFT, and saturate at its maximum value.
REQ-024 SS_n=1 in SKIP_1st or SHIFT SHALL go to IDLE, set rdy, set frame_err if the count != FRAME_W, and latch chnl <= rx[ADDR_LSB +: $clog2(NUM_CH)].
REQ-025 MISO SHALL equal tx[FRAME_W-1] while SS_n=0.
REQ-026 cmd SHALL equal the rx register continuously.
REQ-027 rdy SHALL hold from set until the next SS_n fall is seen in IDLE, a minimum of 1 cycle.
REQ-028 If the rise and fall events and SS_n=1 coincide in the same cycle, SS_n=1 SHALL take priority for the state transition, and the shift SHALL still occur.
REQ-029 If a frame ends with SS_n rising early, the block SHALL still latch chnl from the partial rx contents and assert frame_err.

Reset
REQ-030 When rst_n=0 at a clk edge, the block SHALL set state=IDLE, tx=0, rx=0, chnl=0, rdy=0, frame_err=0, the first-frame flag=1 and the SCLK flops=1.
REQ-031 rst_n=0 mid-frame SHALL abort the frame without asserting rdy.

Configuration
REQ-032 With LOOPBACK_EN defined, every frame after the first SHALL return the previous frame's cmd word instead of channel data, and chnl SHALL still update.
REQ-033 With LOOPBACK_EN undefined, the block SHALL behave as in REQ-020.

Structure
REQ-034 Package spi_a2d_pkg SHALL hold the state_t enum (IDLE, SKIP_1st, SHIFT) and default parameter constants.
REQ-035 The SCLK synchroniser and edge detector SHALL be the sub-module spi_edge_det (outputs rise and fall).

Verification
REQ-036 First frame after reset, with the master sending 16'h1800: MISO SHALL shift out 16'hABCD, then cmd=16'h1800, chnl=3, rdy=1 and frame_err=0.
REQ-037 Second frame, with channel 3 = 12'h5A5: MISO SHALL shift out 16'h05A5.
REQ-038 Sweep of channels 0..7 with distinct values 12'h100+k: each frame SHALL return the channel addressed in the preceding frame.
REQ-039 Frame aborted after 9 SCLK rises: the block SHALL assert rdy=1 and frame_err=1, and the next frame SHALL assert frame_err=0 after 16 rises.
REQ-040 rst_n=0 mid-frame at bit 5: the block SHALL keep rdy=0, and the next frame SHALL return 16'hABCD.
REQ-041 With LOOPBACK_EN defined, sending 16'h1234 then 16'h0000: the second frame SHALL return 16'h1234.
